// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, states, ALU/SEU codes,
// instruction classes and the per-state control-word builder.
package control_pkg;

    localparam logic [10:0] OP_ADD     = 11'b10001011000;
    localparam logic [10:0] OP_SUB     = 11'b11001011000;
    localparam logic [10:0] OP_AND     = 11'b10001010000;
    localparam logic [10:0] OP_ORR     = 11'b10101010000;
    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    // Opcodes with don't-care low bits are matched on their fixed upper bits only
    localparam logic [9:0]  OP_ADDI_HI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI_HI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ_HI = 8'b10110101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b101,
        S_ESPERA = 3'b110
    } estado_t;

    typedef enum logic [2:0] {
        ALU_AND    = 3'b000,
        ALU_ORR    = 3'b001,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_PASS_B = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        SEU_I  = 2'b00,
        SEU_D  = 2'b01,
        SEU_CB = 2'b10
    } seu_t;

    typedef enum logic [3:0] {
        C_ILEGAL = 4'd0,
        C_ADD, C_SUB, C_AND, C_ORR,
        C_ADDI, C_SUBI,
        C_LDUR, C_STUR,
        C_CBZ, C_CBNZ
    } clase_t;

    typedef struct packed {
        logic       ir_wr;
        logic       pc_wr;
        logic       reg2loc;
        logic [1:0] seu;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       beq;
        logic       bne;
    } ctrl_t;

    function automatic logic es_fin(estado_t s, clase_t c);
        return (s == S_EXEC && (c == C_CBZ || c == C_CBNZ)) ||
               (s == S_MEM  && c == C_STUR) ||
               (s == S_WB);
    endfunction

    // Control word to present while the FSM sits in state s for class c
    function automatic ctrl_t ctrl_for(estado_t s, clase_t c);
        ctrl_t o;
        o = '0;
        case (s)
            S_FETCH: o.ir_wr = 1'b1;
            S_EXEC, S_MEM, S_WB: begin
                case (c)
                    C_ADD:  o.alu_op = ALU_ADD;
                    C_SUB:  o.alu_op = ALU_SUB;
                    C_AND:  o.alu_op = ALU_AND;
                    C_ORR:  o.alu_op = ALU_ORR;
                    C_ADDI: begin o.alu_op = ALU_ADD; o.alu_src = 1'b1; o.seu = SEU_I; end
                    C_SUBI: begin o.alu_op = ALU_SUB; o.alu_src = 1'b1; o.seu = SEU_I; end
                    C_LDUR: begin o.alu_op = ALU_ADD; o.alu_src = 1'b1; o.seu = SEU_D; end
                    C_STUR: begin
                        o.alu_op  = ALU_ADD;
                        o.alu_src = 1'b1;
                        o.seu     = SEU_D;
                        o.reg2loc = 1'b1;
                    end
                    C_CBZ, C_CBNZ: begin
                        o.alu_op  = ALU_PASS_B;
                        o.seu     = SEU_CB;
                        o.reg2loc = 1'b1;
                    end
                    default: o = '0;
                endcase
                o.pc_wr      = es_fin(s, c);
                o.mem_wr     = (s == S_MEM) && (c == C_STUR);
                o.reg_wr     = (s == S_WB);
                o.mem_to_reg = (s == S_WB) && (c == C_LDUR);
                o.beq        = (s == S_EXEC) && (c == C_CBZ);
                o.bne        = (s == S_EXEC) && (c == C_CBNZ);
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/control_multiciclo_decodificador_opcode.sv
// Combinational opcode-to-instruction-class decoder; unmatched opcodes map to C_ILEGAL.
module decodificador_opcode
    import control_pkg::*;
(
    input  logic [10:0] opcode,
    output clase_t      clase
);

    always_comb begin
        clase = C_ILEGAL;
        if      (opcode == OP_ADD)            clase = C_ADD;
        else if (opcode == OP_SUB)            clase = C_SUB;
        else if (opcode == OP_AND)            clase = C_AND;
        else if (opcode == OP_ORR)            clase = C_ORR;
        else if (opcode == OP_LDUR)           clase = C_LDUR;
        else if (opcode == OP_STUR)           clase = C_STUR;
        else if (opcode[10:1] == OP_ADDI_HI)  clase = C_ADDI;
        else if (opcode[10:1] == OP_SUBI_HI)  clase = C_SUBI;
        else if (opcode[10:3] == OP_CBZ_HI)   clase = C_CBZ;
        else if (opcode[10:3] == OP_CBNZ_HI)  clase = C_CBNZ;
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with registered control
// outputs, single-step wait state and a sticky illegal-opcode halt.
module control_multiciclo
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode,
    input  logic        modo_paso,
    input  logic        paso,
    output logic        bus_reg2loc,
    output logic [1:0]  bus_seu,
    output logic        bus_aluSrc,
    output logic [2:0]  bus_aluOp,
    output logic        bus_memWr,
    output logic        bus_memToReg,
    output logic        bus_regWr,
    output logic        beq,
    output logic        bne,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic [2:0]  estado,
    output logic        ilegal
);

    estado_t estado_q;
    estado_t fin_sig;
    estado_t avance;
    clase_t  cls_q;
    clase_t  cls_dec;
    ctrl_t   ctrl_q;
    logic    paso_q;
    logic    ilegal_q;

    decodificador_opcode u_dec (
        .opcode (opcode),
        .clase  (cls_dec)
    );

    always_comb begin
        fin_sig = modo_paso ? S_ESPERA : S_FETCH;
        avance  = S_WB;
        if (estado_q == S_EXEC && (cls_q == C_LDUR || cls_q == C_STUR))
            avance = S_MEM;
    end

    // Outputs are registered alongside the state, so they are loaded with the word of the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= S_FETCH;
            cls_q    <= C_ILEGAL;
            ctrl_q   <= '0;
            paso_q   <= 1'b0;
            ilegal_q <= 1'b0;
        end else begin
            paso_q <= paso;
            case (estado_q)
                S_FETCH: begin
                    // ir_wr low in FETCH only right after reset: spend the first edge issuing a real fetch
                    if (!ctrl_q.ir_wr) begin
                        estado_q <= S_FETCH;
                        ctrl_q   <= ctrl_for(S_FETCH, cls_q);
                    end else begin
                        estado_q <= S_DECODE;
                        ctrl_q   <= '0;
                    end
                end
                S_DECODE: begin
                    cls_q <= cls_dec;
                    if (cls_dec == C_ILEGAL) begin
                        estado_q <= S_HALT;
                        ctrl_q   <= '0;
                        ilegal_q <= 1'b1;
                    end else begin
                        estado_q <= S_EXEC;
                        ctrl_q   <= ctrl_for(S_EXEC, cls_dec);
                    end
                end
                S_EXEC, S_MEM, S_WB: begin
                    if (es_fin(estado_q, cls_q)) begin
                        estado_q <= fin_sig;
                        ctrl_q   <= ctrl_for(fin_sig, cls_q);
                    end else begin
                        estado_q <= avance;
                        ctrl_q   <= ctrl_for(avance, cls_q);
                    end
                end
                S_ESPERA: begin
                    if (!modo_paso || (paso && !paso_q)) begin
                        estado_q <= S_FETCH;
                        ctrl_q   <= ctrl_for(S_FETCH, cls_q);
                    end else begin
                        ctrl_q   <= '0;
                    end
                end
                S_HALT: begin
                    ctrl_q <= '0;
                end
                default: begin
                    estado_q <= S_FETCH;
                    ctrl_q   <= '0;
                end
            endcase
        end
    end

    assign estado       = estado_q;
    assign ilegal       = ilegal_q;
    assign ir_wr        = ctrl_q.ir_wr;
    assign pc_wr        = ctrl_q.pc_wr;
    assign bus_reg2loc  = ctrl_q.reg2loc;
    assign bus_seu      = ctrl_q.seu;
    assign bus_aluSrc   = ctrl_q.alu_src;
    assign bus_aluOp    = ctrl_q.alu_op;
    assign bus_memWr    = ctrl_q.mem_wr;
    assign bus_memToReg = ctrl_q.mem_to_reg;
    assign bus_regWr    = ctrl_q.reg_wr;
    assign beq          = ctrl_q.beq;
    assign bne          = ctrl_q.bne;

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo: random instruction stream against a
// per-cycle model built from the instruction table, plus step mode, reset and illegal cases.
module tb_control_multiciclo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] opcode = '0;
    logic        modo_paso = 1'b0;
    logic        paso = 1'b0;
    logic        bus_reg2loc, bus_aluSrc, bus_memWr, bus_memToReg, bus_regWr;
    logic [1:0]  bus_seu;
    logic [2:0]  bus_aluOp;
    logic        beq, bne, ir_wr, pc_wr, ilegal;
    logic [2:0]  estado;

    int n_checks = 0;
    int n_fail   = 0;

    control_multiciclo dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .modo_paso    (modo_paso),
        .paso         (paso),
        .bus_reg2loc  (bus_reg2loc),
        .bus_seu      (bus_seu),
        .bus_aluSrc   (bus_aluSrc),
        .bus_aluOp    (bus_aluOp),
        .bus_memWr    (bus_memWr),
        .bus_memToReg (bus_memToReg),
        .bus_regWr    (bus_regWr),
        .beq          (beq),
        .bne          (bne),
        .ir_wr        (ir_wr),
        .pc_wr        (pc_wr),
        .estado       (estado),
        .ilegal       (ilegal)
    );

    always #5 clk = ~clk;

    // Instruction table: ADD SUB AND ORR ADDI SUBI LDUR STUR CBZ CBNZ
    string       name  [10] = '{"ADD", "SUB", "AND", "ORR", "ADDI", "SUBI", "LDUR", "STUR", "CBZ", "CBNZ"};
    logic [10:0] base  [10] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                                11'b10010001000, 11'b11010001000, 11'b11111000010, 11'b11111000000,
                                11'b10110100000, 11'b10110101000};
    logic [10:0] mask  [10] = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd0, 11'd0, 11'd7, 11'd7};
    int          ncyc  [10] = '{4, 4, 4, 4, 4, 4, 5, 4, 3, 3};
    logic [2:0]  aop_t [10] = '{3'b010, 3'b011, 3'b000, 3'b001, 3'b010, 3'b011, 3'b010, 3'b010, 3'b100, 3'b100};
    logic [1:0]  seu_t [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic        src_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        r2l_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    localparam logic [16:0] REC_ESPERA = {3'b110, 14'd0};
    localparam logic [16:0] REC_HALT   = {3'b101, 14'd0};

    function automatic logic [16:0] obs_vec();
        return {estado, ir_wr, pc_wr, bus_reg2loc, bus_seu, bus_aluSrc, bus_aluOp,
                bus_memWr, bus_memToReg, bus_regWr, beq, bne};
    endfunction

    // Expected outputs for cycle k (0 = FETCH) of instruction i
    function automatic logic [16:0] exp_rec(int i, int k);
        int         n;
        logic [2:0] st;
        logic [2:0] aop;
        logic [1:0] seu;
        logic       src, r2l, last, mem, wb;
        n = ncyc[i];
        case (k)
            0:       st = 3'b000;
            1:       st = 3'b001;
            2:       st = 3'b010;
            3:       st = (i == 6 || i == 7) ? 3'b011 : 3'b100;
            default: st = 3'b100;
        endcase
        aop = '0; seu = '0; src = 1'b0; r2l = 1'b0;
        if (k >= 2) begin
            aop = aop_t[i]; seu = seu_t[i]; src = src_t[i]; r2l = r2l_t[i];
        end
        last = (k == n - 1);
        mem  = (st == 3'b011);
        wb   = (st == 3'b100);
        return {st, k == 0, last, r2l, seu, src, aop,
                mem && i == 7, wb && i == 6, wb, i == 8 && last, i == 9 && last};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; returns at a negedge with the DUT in FETCH
    task automatic run_instr(input int i, input logic modo, input int abort_k, input int wake);
        int n;
        n = ncyc[i];
        modo_paso = modo;
        paso      = modo;
        opcode    = base[i] | (11'($urandom) & mask[i]);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("%s k%0d", name[i], k), 32'(obs_vec()), 32'(exp_rec(i, k)));
            if (k == abort_k) begin
                #1 rst = 1'b1;
                #1 chk($sformatf("%s rst k%0d", name[i], k), 32'(obs_vec()), 32'd0);
                chk("ilegal after rst", 32'(ilegal), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                modo_paso = 1'b0;
                paso = 1'b0;
                @(negedge clk);
                return;
            end
            if (k == 1) begin
                @(posedge clk);
                #1 opcode = 11'($urandom);
            end
        end
        @(negedge clk);
        if (modo) begin
            chk("espera entry", 32'(obs_vec()), 32'(REC_ESPERA));
            repeat (3) begin
                @(negedge clk);
                chk("espera paso held", 32'(obs_vec()), 32'(REC_ESPERA));
            end
            if (wake == 0) begin
                paso = 1'b0;
                @(negedge clk);
                chk("espera paso low", 32'(obs_vec()), 32'(REC_ESPERA));
                paso = 1'b1;
            end else begin
                modo_paso = 1'b0;
            end
            @(negedge clk);
            chk("espera wake", 32'(estado), 32'd0);
            paso = 1'b0;
        end
    endtask

    task automatic run_illegal(input logic [10:0] op);
        modo_paso = 1'b0;
        paso = 1'b0;
        opcode = op;
        chk("illegal fetch", 32'(obs_vec()), 32'(exp_rec(0, 0)));
        @(negedge clk);
        chk("illegal decode", 32'(obs_vec()), 32'(exp_rec(0, 1)));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            opcode = 11'($urandom);
            chk($sformatf("halt c%0d", c), 32'(obs_vec()), 32'(REC_HALT));
            chk("halt ilegal", 32'(ilegal), 32'd1);
        end
        rst = 1'b1;
        #1 chk("halt rst", 32'(obs_vec()), 32'd0);
        chk("halt rst ilegal", 32'(ilegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("reset outputs", 32'(obs_vec()), 32'd0);
        chk("reset ilegal", 32'(ilegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_instr(0, 1'b0, -1, 0);
        run_instr(6, 1'b0, -1, 0);
        run_instr(7, 1'b0, -1, 0);
        run_instr(9, 1'b0, -1, 0);
        run_instr(8, 1'b0, -1, 0);
        run_instr(4, 1'b1, -1, 0);
        run_instr(5, 1'b1, -1, 1);

        repeat (60) begin
            run_instr($urandom_range(0, 9), ($urandom_range(0, 3) == 0), -1, $urandom_range(0, 1));
        end

        run_instr(7, 1'b0, 3, 0);
        run_instr(0, 1'b0, 3, 0);
        run_instr(6, 1'b0, 4, 0);
        run_instr(2, 1'b0, -1, 0);

        run_illegal(11'b00000000000);
        run_illegal(11'b11111111111);
        run_illegal(11'b10001011001);
        run_instr(3, 1'b0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
